uart_tx_fifo: RTL and testbench

- UART transmitter for the return path of the vga_uart system: 8N1, LSB first, on `tx`.
- Sends processed (Sobel edge) bytes back to the host.
- A 16-entry FIFO decouples the bursty pixel producer from the fixed-rate serial line.
- Same 50 MHz / 115200 baud framing as the existing UART receiver, so the two loop back directly.

---
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-producer side of the UART transmitter: write strobe, data and FIFO status.
// The producer uses the master modport; the transmitter uses the slave modport.
interface uart_tx_fifo_if #(
   parameter int FIFO_AW = 4
);
   logic [7:0]       pi_data;
   logic             pi_flag;
   logic             pi_full;
   logic [FIFO_AW:0] fifo_cnt;
   logic             ovf;

   modport master (
      output pi_data,
      output pi_flag,
      input  pi_full,
      input  fifo_cnt,
      input  ovf
   );

   modport slave (
      input  pi_data,
      input  pi_flag,
      output pi_full,
      output fifo_cnt,
      output ovf
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first) fed by a 16-entry byte FIFO.
// Frames are sent back to back while the FIFO holds data.
module uart_tx_fifo #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200,
   parameter int FIFO_AW  = 4
) (
   input  logic              sclk,
   input  logic              rst_n,
   uart_tx_fifo_if.slave     bus,
   output logic              tx,
   output logic              tx_busy
);
   localparam int BAUD_CNT = CLK_FREQ / BAUD;
   localparam int BW       = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
   localparam int DEPTH    = 2 ** FIFO_AW;
   localparam int CW       = FIFO_AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [BW-1:0]      baud_cnt_q, baud_cnt_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [7:0]         shift_q, shift_d;
   logic               tx_q, tx_d;
   logic               tx_busy_q, tx_busy_d;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d;
   logic               pi_full_q, pi_full_d;
   logic               ovf_q, ovf_d;

   logic [7:0]         mem [DEPTH];
   logic               wr_en;
   logic               pop;
   logic               baud_last;

   assign baud_last = (baud_cnt_q == BW'(BAUD_CNT - 1));

   // A write seen while full is lost even if a pop frees a slot this cycle.
   assign wr_en = bus.pi_flag & ~pi_full_q;

   always_ff @(posedge sclk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= bus.pi_data;
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      ovf_d      = bus.pi_flag & pi_full_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      end
      case ({wr_en, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
      pi_full_d = (fifo_cnt_d == CW'(DEPTH));
   end

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_busy_d  = tx_busy_q;
      pop        = 1'b0;
      unique case (state_q)
         IDLE: begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            tx_busy_d  = 1'b0;
            if (fifo_cnt_q != '0) begin
               pop       = 1'b1;
               shift_d   = mem[rd_ptr_q];
               tx_busy_d = 1'b1;
               state_d   = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + BW'(1);
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               shift_d    = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + BW'(1);
            end
         end
         STOP: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               // Chain straight into the next START so frames have no idle gap.
               if (fifo_cnt_q != '0) begin
                  pop     = 1'b1;
                  shift_d = mem[rd_ptr_q];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // The line level is registered, so derive it from the state being entered.
      tx_d = 1'b1;
      if (state_d == START) begin
         tx_d = 1'b0;
      end else if (state_d == DATA) begin
         tx_d = shift_d[0];
      end
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         tx_busy_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         pi_full_q  <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         tx_busy_q  <= tx_busy_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         pi_full_q  <= pi_full_d;
         ovf_q      <= ovf_d;
      end
   end

   assign tx           = tx_q;
   assign tx_busy      = tx_busy_q;
   assign bus.pi_full  = pi_full_q;
   assign bus.fifo_cnt = fifo_cnt_q;
   assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; a line monitor decodes frames from tx.
// Baud rate is scaled so one bit lasts BC clocks to keep runs short.
module tb_uart_tx_fifo;
   localparam int BC = 16;

   logic sclk;
   logic rst_n;
   logic tx;
   logic tx_busy;
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   frame_errs;
   logic [7:0] rx_q[$];
   int         st_q[$];

   uart_tx_fifo_if #(.FIFO_AW(4)) bus ();

   uart_tx_fifo #(
      .CLK_FREQ (1600000),
      .BAUD     (100000),
      .FIFO_AW  (4)
   ) dut (
      .sclk    (sclk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .tx      (tx),
      .tx_busy (tx_busy)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   initial cyc = 0;
   always @(posedge sclk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end else begin
         $display("check %s ok value=%0h", tag, got);
      end
   endtask

   task automatic wait_frames(input int n, input int limit);
      for (int i = 0; i < limit && rx_q.size() < n; i++) tick();
   endtask

   // Line monitor: samples at negedge, abandons a frame when reset hits.
   initial begin
      frame_errs = 0;
      forever begin
         @(negedge sclk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            logic [7:0] b;
            int         bad;
            int         st;
            bit         abort;
            logic       ref_bit;
            b = 8'h00; bad = 0; abort = 1'b0; ref_bit = 1'b0; st = cyc;
            for (int c = 0; c < 10 * BC; c++) begin
               if (c > 0) @(negedge sclk);
               if (rst_n !== 1'b1) begin
                  abort = 1'b1;
                  break;
               end
               if (c % BC == 0) ref_bit = tx;
               if (c / BC == 0) begin
                  if (tx !== 1'b0) bad++;
               end else if (c / BC == 9) begin
                  if (tx !== 1'b1) bad++;
               end else begin
                  if (tx !== ref_bit) bad++;
                  if (c % BC == 0) b[c / BC - 1] = tx;
               end
            end
            if (!abort) begin
               rx_q.push_back(b);
               st_q.push_back(st);
               frame_errs += bad;
            end
         end
      end
   end

   initial begin
      int n0;
      int b0;
      int s0;
      int busy_n;
      int ovf_n;
      int full_at;
      int gap_bad;
      bit seen;

      n_checks = 0;
      n_fail   = 0;
      rst_n        = 1'b0;
      bus.pi_flag  = 1'b0;
      bus.pi_data  = 8'h00;

      // Reset values, during and after reset.
      repeat (3) tick();
      check_eq("rst_tx", tx, 1);
      check_eq("rst_busy", tx_busy, 0);
      check_eq("rst_full", bus.pi_full, 0);
      check_eq("rst_cnt", bus.fifo_cnt, 0);
      check_eq("rst_ovf", bus.ovf, 0);
      rst_n = 1'b1;
      repeat (2) tick();
      check_eq("post_rst_tx", tx, 1);
      check_eq("post_rst_cnt", bus.fifo_cnt, 0);

      // Single 0x55 into an idle block.
      n0 = cyc;
      bus.pi_data = 8'h55;
      bus.pi_flag = 1'b1;
      tick();
      bus.pi_flag = 1'b0;
      check_eq("t1_cnt_n1", bus.fifo_cnt, 1);
      check_eq("t1_tx_n1", tx, 1);
      check_eq("t1_busy_n1", tx_busy, 0);
      busy_n = 0;
      seen   = 1'b0;
      for (int i = 0; i < 20 * BC; i++) begin
         if (tx_busy === 1'b1) begin
            busy_n++;
            seen = 1'b1;
         end else if (seen) begin
            break;
         end
         tick();
      end
      check_eq("t1_busy_len", busy_n, 10 * BC + 1);
      check_eq("t1_frames", rx_q.size(), 1);
      if (rx_q.size() >= 1) begin
         check_eq("t1_byte", rx_q[0], 8'h55);
         check_eq("t1_start_cycle", st_q[0], n0 + 2);
      end
      check_eq("t1_frame_errs", frame_errs, 0);

      // Two bytes on consecutive cycles: back-to-back frames.
      rx_q.delete();
      st_q.delete();
      bus.pi_data = 8'hA5;
      bus.pi_flag = 1'b1;
      tick();
      check_eq("t2_cnt_n1", bus.fifo_cnt, 1);
      bus.pi_data = 8'h3C;
      tick();
      bus.pi_flag = 1'b0;
      check_eq("t2_cnt_n2", bus.fifo_cnt, 1);
      check_eq("t2_tx_n2", tx, 0);
      wait_frames(2, 30 * BC);
      check_eq("t2_frames", rx_q.size(), 2);
      if (rx_q.size() >= 2) begin
         check_eq("t2_byte0", rx_q[0], 8'hA5);
         check_eq("t2_byte1", rx_q[1], 8'h3C);
         check_eq("t2_gap", st_q[1] - st_q[0], 10 * BC);
      end
      check_eq("t2_cnt_end", bus.fifo_cnt, 0);
      check_eq("t2_frame_errs", frame_errs, 0);
      repeat (4) tick();

      // Burst of 20 writes, then a write while full on the pop cycle.
      rx_q.delete();
      st_q.delete();
      b0      = cyc;
      ovf_n   = 0;
      full_at = -1;
      for (int i = 0; i < 20; i++) begin
         bus.pi_data = 8'h10 + 8'(i);
         bus.pi_flag = 1'b1;
         tick();
         if (bus.ovf === 1'b1) ovf_n++;
         if (bus.pi_full === 1'b1 && full_at < 0) full_at = i;
      end
      bus.pi_flag = 1'b0;
      check_eq("t3_cnt", bus.fifo_cnt, 16);
      check_eq("t3_ovf_pulses", ovf_n, 3);
      check_eq("t3_full_at", full_at, 16);
      while (cyc < b0 + 1 + 10 * BC) tick();
      check_eq("t4_full_before", bus.pi_full, 1);
      bus.pi_data = 8'hEE;
      bus.pi_flag = 1'b1;
      tick();
      bus.pi_flag = 1'b0;
      check_eq("t4_ovf", bus.ovf, 1);
      check_eq("t4_cnt", bus.fifo_cnt, 15);
      check_eq("t4_full_after", bus.pi_full, 0);
      wait_frames(17, 20 * 10 * BC);
      check_eq("t3_frames", rx_q.size(), 17);
      gap_bad = 0;
      for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
         check_eq($sformatf("t3_byte%0d", i), rx_q[i], 8'h10 + 8'(i));
         if (i > 0 && st_q[i] - st_q[i-1] != 10 * BC) gap_bad++;
      end
      check_eq("t3_gaps", gap_bad, 0);
      repeat (2 * 10 * BC) tick();
      check_eq("t4_no_extra_frame", rx_q.size(), 17);
      check_eq("t3_busy_end", tx_busy, 0);
      check_eq("t3_frame_errs", frame_errs, 0);

      // Reset during DATA bit 4 of a queued 3-byte transfer.
      rx_q.delete();
      st_q.delete();
      n0 = cyc;
      for (int i = 0; i < 3; i++) begin
         bus.pi_data = 8'h11 * 8'(i);
         bus.pi_flag = 1'b1;
         tick();
      end
      bus.pi_flag = 1'b0;
      s0 = n0 + 2;
      while (cyc < s0 + 5 * BC + 3) tick();
      check_eq("t5_tx_bit4", tx, 0);
      rst_n = 1'b0;
      #1;
      check_eq("t5_tx_async", tx, 1);
      check_eq("t5_cnt_async", bus.fifo_cnt, 0);
      check_eq("t5_busy_async", tx_busy, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3 * 10 * BC) tick();
      check_eq("t5_no_frames", rx_q.size(), 0);
      check_eq("t5_tx_idle", tx, 1);
      check_eq("t5_cnt_idle", bus.fifo_cnt, 0);
      bus.pi_data = 8'h81;
      bus.pi_flag = 1'b1;
      tick();
      bus.pi_flag = 1'b0;
      wait_frames(1, 20 * BC);
      check_eq("t5_new_frames", rx_q.size(), 1);
      if (rx_q.size() >= 1) check_eq("t5_new_byte", rx_q[0], 8'h81);
      check_eq("t5_frame_errs", frame_errs, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
